// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase encodings, default durations, state enum and duration helper
package traffic_pkg;

    localparam int PH_GREEN  = 0;
    localparam int PH_YELLOW = 1;
    localparam int PH_RED    = 2;

    localparam int DEF_GREEN  = 5;
    localparam int DEF_YELLOW = 2;
    localparam int DEF_RED    = 3;

    // Widest duration the helper handles; callers zero-extend into it.
    localparam int DUR_MAX_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A programmed duration of 0 behaves as 1 cycle so the counter never underflows.
    function automatic logic [DUR_MAX_W-1:0] eff(input logic [DUR_MAX_W-1:0] d);
        return (d == '0) ? DUR_MAX_W'(1) : d;
    endfunction

endpackage

// File: rtl/reload_downcounter.sv
// rtl/reload_downcounter.sv - reloadable down-counter that saturates at zero
module reload_downcounter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - multi-phase terminal-count timer with tick/done pulses
module phase_counter
    import traffic_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int NUM_PHASES = 3,
    localparam int PW         = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        enable,
    input  logic                        loop_mode,
    input  logic [NUM_PHASES*WIDTH-1:0] durations,
    output logic [PW-1:0]               phase,
    output logic [WIDTH-1:0]            count,
    output logic                        busy,
    output logic                        phase_tick,
    output logic                        seq_done
);

    localparam logic [PW-1:0] LAST_PHASE  = PW'(NUM_PHASES - 1);
    localparam logic [PW-1:0] FIRST_PHASE = PW'(PH_GREEN);

    state_t           state, state_nxt;
    logic [PW-1:0]    phase_nxt;
    logic [PW-1:0]    next_idx;
    logic             busy_nxt, tick_nxt, done_nxt;
    logic             cnt_load, cnt_en, cnt_zero;
    logic [WIDTH-1:0] cnt_load_val;
    logic [WIDTH-1:0] first_val, next_val;

    // The phase after the last one is phase 0, so advance and wrap share one load value.
    assign next_idx  = (phase == LAST_PHASE) ? FIRST_PHASE : phase + 1'b1;
    assign first_val = WIDTH'(eff(DUR_MAX_W'(durations[0 +: WIDTH])) - 1'b1);
    assign next_val  = WIDTH'(eff(DUR_MAX_W'(durations[next_idx*WIDTH +: WIDTH])) - 1'b1);

    reload_downcounter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .load_val(cnt_load_val),
        .enable  (cnt_en),
        .count   (count),
        .zero    (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= '0;
            busy       <= 1'b0;
            phase_tick <= 1'b0;
            seq_done   <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            busy       <= busy_nxt;
            phase_tick <= tick_nxt;
            seq_done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        busy_nxt     = busy;
        tick_nxt     = 1'b0;
        done_nxt     = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;

        // start wins over pause and terminal count in both states.
        if (start) begin
            state_nxt    = RUN;
            phase_nxt    = FIRST_PHASE;
            busy_nxt     = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = first_val;
        end else if (state == RUN && enable) begin
            if (!cnt_zero) begin
                cnt_en = 1'b1;
            end else begin
                tick_nxt = 1'b1;
                if (phase != LAST_PHASE) begin
                    phase_nxt    = next_idx;
                    cnt_load     = 1'b1;
                    cnt_load_val = next_val;
                end else begin
                    done_nxt  = 1'b1;
                    phase_nxt = FIRST_PHASE;
                    cnt_load  = 1'b1;
                    if (loop_mode) begin
                        cnt_load_val = next_val;
                    end else begin
                        state_nxt    = IDLE;
                        busy_nxt     = 1'b0;
                        cnt_load_val = '0;
                    end
                end
            end
        end
    end

endmodule
